// File: rtl/seq_mult_32_pkg.sv
// Shared constants and FSM encoding for the 32x32 signed shift-add multiplier.
package seq_mult_32_pkg;

   localparam int DATA_W = 32;
   localparam int PROD_W = 2 * DATA_W;
   localparam int ITERS  = 32;
   localparam int CNT_W  = $clog2(ITERS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/TWOSCOMP32.sv
// 32-bit two's-complement negation cell.
module TWOSCOMP32 (
   input  logic [31:0] a,
   output logic [31:0] y
);

   assign y = ~a + 32'd1;

endmodule

// File: rtl/TWOSCOMP64.sv
// 64-bit two's-complement negation cell.
module TWOSCOMP64 (
   input  logic [63:0] a,
   output logic [63:0] y
);

   assign y = ~a + 64'd1;

endmodule

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// accumulator half, then shift {carry, accumulator} right by one.
module mult_step
   import seq_mult_32_pkg::*;
(
   input  logic [PROD_W-1:0] acc_i,
   input  logic [DATA_W-1:0] mcand_i,
   input  logic              mbit_i,
   output logic [PROD_W-1:0] acc_o
);

   logic [DATA_W:0] sum;
   logic            unused_lsb;

   assign sum        = {1'b0, acc_i[PROD_W-1:DATA_W]} + (mbit_i ? {1'b0, mcand_i} : '0);
   assign acc_o      = {sum, acc_i[DATA_W-1:1]};
   // The accumulator LSB falls off the end of the shift.
   assign unused_lsb = acc_i[0];

endmodule

// File: rtl/seq_mult_32.sv
// Sequential signed 32x32 -> 64 multiplier: magnitudes are multiplied over
// 32 shift-add cycles, then the sign is applied in a single fix-up cycle.
module seq_mult_32
   import seq_mult_32_pkg::*;
#(
   parameter int DATA_W = seq_mult_32_pkg::DATA_W
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] HI,
   output logic [DATA_W-1:0] LO,
   output logic              BUSY,
   output logic              DONE
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   mcand_q, mcand_d;
   logic [DATA_W-1:0]   mplier_q, mplier_d;
   logic                sign_q, sign_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [DATA_W-1:0]   a_neg, b_neg, a_mag, b_mag;
   logic [PROD_W-1:0]   acc_step, acc_neg;

   // 0x80000000 negates to itself, which read unsigned is the correct 2^31.
   TWOSCOMP32 u_neg_a (.a(A), .y(a_neg));
   TWOSCOMP32 u_neg_b (.a(B), .y(b_neg));
   TWOSCOMP64 u_neg_p (.a(acc_q), .y(acc_neg));

   assign a_mag = A[DATA_W-1] ? a_neg : A;
   assign b_mag = B[DATA_W-1] ? b_neg : B;

   mult_step u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .mbit_i  (mplier_q[0]),
      .acc_o   (acc_step)
   );

   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the case infers a latch.
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         ST_IDLE: if (START) begin
            mcand_d  = a_mag;
            mplier_d = b_mag;
            sign_d   = A[DATA_W-1] ^ B[DATA_W-1];
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            {hi_d, lo_d} = sign_q ? acc_neg : acc_q;
            state_d      = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Status outputs are registered from the next state so they line up with it.
      busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
      done_d = (state_d == ST_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign HI   = hi_q;
   assign LO   = lo_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Scoreboard bench for seq_mult_32: a driver queues expected products from a
// plain signed-multiply model, a monitor checks every DONE, BUSY and HI/LO hold.
module tb_seq_mult_32;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        START;
   logic [31:0] A, B;
   logic [31:0] HI, LO;
   logic        BUSY, DONE;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          done_cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          busy_from = 0;
   bit          busy_on   = 1'b0;
   bit          mon_en    = 1'b0;
   logic [63:0] last_res  = '0;

   seq_mult_32 dut (
      .CLK   (CLK),
      .RESET (RESET),
      .START (START),
      .A     (A),
      .B     (B),
      .HI    (HI),
      .LO    (LO),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Issue one multiply; call at posedge+1. Returns at posedge+1 of cycle 1.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      p          = longint'($signed(a)) * longint'($signed(b));
      e.hi       = p[63:32];
      e.lo       = p[31:0];
      e.done_cyc = cyc + 34;
      sb.push_back(e);
      busy_from  = cyc + 1;
      busy_on    = 1'b1;
      A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      A = $urandom; B = $urandom;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 80 && sb.size() != 0; i++) begin
         @(posedge CLK); #1;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'h0000_0000;
         1:       v = 32'h0000_0001;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: DONE pops the scoreboard; BUSY and HI/LO hold checked every cycle.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (DONE) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("hi", 64'(HI), 64'(e.hi));
               check("lo", 64'(LO), 64'(e.lo));
               check("done_cycle", 64'(cyc), 64'(e.done_cyc));
               last_res = {e.hi, e.lo};
            end
         end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
            check("done_missing", 64'(DONE), 64'd1);
            void'(sb.pop_front());
         end
         check("busy", 64'(BUSY),
               64'(busy_on && cyc >= busy_from && cyc <= busy_from + 32));
         check("hold", {HI, LO}, last_res);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; START = 1'b0; A = '0; B = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      check("reset_hi", 64'(HI), 64'd0);
      check("reset_lo", 64'(LO), 64'd0);
      check("reset_busy", 64'(BUSY), 64'd0);
      check("reset_done", 64'(DONE), 64'd0);
      mon_en = 1'b1;
      @(posedge CLK); #1;

      start_op(32'd3, 32'd5);                 wait_done();
      start_op(32'hFFFF_FFFF, 32'h0000_0007); wait_done();
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
      start_op(32'h8000_0000, 32'h8000_0000); wait_done();
      start_op(32'h7FFF_FFFF, 32'h8000_0000); wait_done();
      start_op(32'h0000_0000, 32'h1234_5678); wait_done();

      // START re-asserted mid-run must be ignored entirely.
      start_op(32'd3, 32'd5);
      repeat (9) begin @(posedge CLK); #1; end
      A = 32'd9; B = 32'd9; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done();
      repeat (40) begin @(posedge CLK); #1; end

      // Reset in cycle 20 of a run, then START in the very first cycle after.
      start_op(32'd3, 32'd5);
      repeat (19) begin @(posedge CLK); #1; end
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      sb.delete();
      busy_on  = 1'b0;
      last_res = '0;
      check("midreset_hi", 64'(HI), 64'd0);
      check("midreset_lo", 64'(LO), 64'd0);
      check("midreset_busy", 64'(BUSY), 64'd0);
      check("midreset_done", 64'(DONE), 64'd0);
      start_op(32'd6, 32'd7);
      wait_done();

      for (int n = 0; n < 24; n++) begin
         start_op(pick_operand(), pick_operand());
         wait_done();
         repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      end

      repeat (3) begin @(posedge CLK); #1; end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
